// File: rtl/spi_master.sv
// rtl/spi_master.sv - Byte-wide SPI master issuing 16-bit {addr, rw, data} frames
module spi_master #(
    parameter int CLKDIV = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_pin,
    output logic       cs_pin,
    output logic       mosi_pin,
    input  logic       miso_pin
);
    localparam int CW = $clog2(2 * CLKDIV + 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(2 * CLKDIV - 1);
    localparam logic [CW-1:0] GAP_PRE   = CW'(2 * CLKDIV - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT_HI,
        S_SHIFT_LO,
        S_GAP
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [15:0]   r_tx;
    logic [7:0]    r_rx;
    logic          r_rw;
    logic          r_busy;
    logic          r_done;
    logic          r_sclk;
    logic          r_cs;
    logic [7:0]    r_rdata;
    logic          w_half_end;
    logic          w_gap_end;
    logic          w_done_nxt;

    assign w_half_end = (r_cnt == HALF_LAST);
    assign w_gap_end  = (r_cnt == GAP_LAST);
    // done and rdata must land in the last GAP cycle, so they are set one cycle early
    assign w_done_nxt = (r_state == S_GAP) && (r_cnt == GAP_PRE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (start) w_state_nxt = S_SETUP;
            S_SETUP:    if (w_half_end) w_state_nxt = S_SHIFT_HI;
            S_SHIFT_HI: if (w_half_end) w_state_nxt = S_SHIFT_LO;
            S_SHIFT_LO: if (w_half_end) w_state_nxt = (r_bit == 4'd15) ? S_GAP : S_SHIFT_HI;
            S_GAP:      if (w_gap_end) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_rw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sclk  <= 1'b0;
            r_cs    <= 1'b1;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_cnt + CNT_ONE;
            r_cs    <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            r_sclk  <= (w_state_nxt == S_SHIFT_HI);
            r_busy  <= (w_state_nxt != S_IDLE) && !w_done_nxt;
            r_done  <= w_done_nxt;

            if (r_state == S_IDLE && start) begin
                r_tx  <= {addr, rw, (rw ? 8'h00 : wdata)};
                r_rw  <= rw;
                r_bit <= '0;
            end
            if (r_state != S_SHIFT_HI && w_state_nxt == S_SHIFT_HI)
                r_rx <= {r_rx[6:0], miso_pin};
            if (r_state == S_SHIFT_HI && w_state_nxt == S_SHIFT_LO)
                r_tx <= {r_tx[14:0], 1'b0};
            if (r_state == S_SHIFT_LO && w_state_nxt == S_SHIFT_HI)
                r_bit <= r_bit + 4'd1;
            // MOSI comes straight from r_tx[15], so clearing it parks the line low
            if (r_state == S_SHIFT_LO && w_state_nxt == S_GAP)
                r_tx <= '0;
            if (w_done_nxt && r_rw)
                r_rdata <= r_rx;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rdata    = r_rdata;
    assign sclk_pin = r_sclk;
    assign cs_pin   = r_cs;
    assign mosi_pin = r_tx[15];

endmodule
